bist_controller: RTL and testbench

BIST_CONTROLLER -- requirements
Module: bist_controller

---
 rtl/bist_pkg.sv | 37 +++
 rtl/tpg_lfsr3.sv | 24 ++
 rtl/bist_controller.sv | 118 +++++++++++
 tb/tb_bist_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the BIST controller and its pattern generator.
// Contents: FSM state encoding, Moore output bundle, LFSR seed/taps and step function.
// Used by: bist_controller, tpg_lfsr3.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_RUN     = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Moore outputs, registered together with the state they belong to.
  typedef struct packed {
    logic test_mode;
    logic misr_clr;
    logic busy;
  } moore_t;

  localparam logic [2:0] LFSR_SEED = 3'b001;
  // Feedback bits: the new q[0] is the XOR of q[2] and q[1].
  localparam logic [2:0] LFSR_TAPS = 3'b110;

  function automatic logic [2:0] lfsr_next(input logic [2:0] q);
    return {q[1], q[0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic moore_t moore_of(input state_t s);
    moore_t m;
    m.test_mode = (s == S_INIT) || (s == S_RUN) || (s == S_COMPARE);
    m.busy      = m.test_mode;
    m.misr_clr  = (s == S_IDLE) || (s == S_INIT) || (s == S_DONE);
    return m;
  endfunction

endpackage

// File: rtl/tpg_lfsr3.sv
// tpg_lfsr3: 3-bit maximal-length LFSR test pattern generator (period 7).
// Ports: clock, reset (async, active-high, loads seed), seed_load (load seed),
//        enable (advance one step), q (current pattern).
module tpg_lfsr3
  import bist_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       seed_load,
  input  logic       enable,
  output logic [2:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else if (seed_load) begin
      q <= LFSR_SEED;
    end else if (enable) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/bist_controller.sv
// bist_controller: runs NUM_PATTERNS LFSR patterns into an adder CUT and checks the MISR signature.
// Ports: clock, reset (async, active-high), start, abort, misr_sig in; tpg_pattern, test_mode,
//        misr_clr, busy, done, pass, sig_captured out (all registered).
module bist_controller
  import bist_pkg::*;
#(
  parameter int         NUM_PATTERNS = 7,
  parameter logic [3:0] GOLDEN_SIG   = 4'h0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] misr_sig,
  output logic [2:0] tpg_pattern,
  output logic       test_mode,
  output logic       misr_clr,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] sig_captured
);

  localparam logic [7:0] LAST_COUNT = 8'(NUM_PATTERNS - 1);

  state_t     state;
  moore_t     moore;
  logic [7:0] count;

  // The LFSR is seeded on the INIT->RUN edge so pattern 0 is visible in the first RUN cycle.
  tpg_lfsr3 u_tpg (
    .clock     (clock),
    .reset     (reset),
    .seed_load (state == S_INIT),
    .enable    (state == S_RUN),
    .q         (tpg_pattern)
  );

  assign test_mode = moore.test_mode;
  assign misr_clr  = moore.misr_clr;
  assign busy      = moore.busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      moore        <= moore_of(S_IDLE);
      count        <= 8'd0;
      done         <= 1'b0;
      pass         <= 1'b0;
      sig_captured <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_INIT;
            moore <= moore_of(S_INIT);
          end
        end
        S_INIT: begin
          if (abort) begin
            state <= S_IDLE;
            moore <= moore_of(S_IDLE);
            done  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            state <= S_RUN;
            moore <= moore_of(S_RUN);
            count <= 8'd0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            moore <= moore_of(S_IDLE);
            done  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            count <= count + 8'd1;
            if (count == LAST_COUNT) begin
              state <= S_COMPARE;
              moore <= moore_of(S_COMPARE);
            end
          end
        end
        S_COMPARE: begin
          if (abort) begin
            state <= S_IDLE;
            moore <= moore_of(S_IDLE);
            done  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            state        <= S_DONE;
            moore        <= moore_of(S_DONE);
            sig_captured <= misr_sig;
            pass         <= (misr_sig == GOLDEN_SIG);
            done         <= 1'b1;
          end
        end
        S_DONE: begin
          // A new run clears the previous verdict; sig_captured is kept until the next COMPARE.
          if (start) begin
            state <= S_INIT;
            moore <= moore_of(S_INIT);
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          moore <= moore_of(S_IDLE);
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: self-checking bench for bist_controller.
// Instance a: NUM_PATTERNS=7, GOLDEN_SIG=A (verdicts, abort, reset). Instance b: NUM_PATTERNS=9 (pattern order).
// Expected verdicts and patterns are queued when stimulus is driven and popped when the DUT responds.
module tb_bist_controller;

  typedef struct packed {
    logic       pass;
    logic [3:0] sig;
  } result_t;

  logic       clock;
  logic       reset;

  logic       start_a, abort_a;
  logic [3:0] misr_a;
  logic [2:0] tpg_a;
  logic       test_mode_a, misr_clr_a, busy_a, done_a, pass_a;
  logic [3:0] sig_a;

  logic       start_b, abort_b;
  logic [3:0] misr_b;
  logic [2:0] tpg_b;
  logic       test_mode_b, misr_clr_b, busy_b, done_b, pass_b;
  logic [3:0] sig_b;

  int vectors;
  int miscompares;

  result_t    res_q[$];
  logic [2:0] pat_q[$];

  bist_controller #(.NUM_PATTERNS(7), .GOLDEN_SIG(4'hA)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .abort(abort_a), .misr_sig(misr_a),
    .tpg_pattern(tpg_a), .test_mode(test_mode_a), .misr_clr(misr_clr_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .sig_captured(sig_a)
  );

  bist_controller #(.NUM_PATTERNS(9), .GOLDEN_SIG(4'hA)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort_b), .misr_sig(misr_b),
    .tpg_pattern(tpg_b), .test_mode(test_mode_b), .misr_clr(misr_clr_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .sig_captured(sig_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({busy_a, done_a, pass_a, test_mode_a, misr_clr_a, sig_a, tpg_a} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 3'b001}) begin
      miscompares++;
      $display("FAIL reset_state: got busy/done/pass/tm/clr/sig/tpg=%b %b %b %b %b %h %b, want 0 0 0 0 1 0 001",
               busy_a, done_a, pass_a, test_mode_a, misr_clr_a, sig_a, tpg_a);
    end
    reset = 1'b0;
  endtask

  // One full run on instance a; misr_a carries sig only during the COMPARE cycle.
  task automatic run7(input logic [3:0] sig, input logic exp_pass);
    result_t r;
    res_q.push_back('{pass: exp_pass, sig: sig});
    start_a = 1'b1;
    misr_a  = ~sig;
    wait_edge();  // edge 0: INIT
    start_a = 1'b0;
    vectors++;
    if ({done_a, pass_a, busy_a, test_mode_a, misr_clr_a} !== 5'b00111) begin
      miscompares++;
      $display("FAIL init_state: got done/pass/busy/tm/clr=%b%b%b%b%b, want 00111",
               done_a, pass_a, busy_a, test_mode_a, misr_clr_a);
    end
    for (int e = 1; e <= 9; e++) begin
      wait_edge();
      if (e == 8) misr_a = sig;
      if (e == 9) misr_a = ~sig;
      if (e < 9) begin
        vectors++;
        if (done_a !== 1'b0 || busy_a !== 1'b1) begin
          miscompares++;
          $display("FAIL early_done: edge %0d got done=%b busy=%b, want done=0 busy=1", e, done_a, busy_a);
        end
      end
    end
    r = res_q.pop_front();
    vectors++;
    if ({done_a, pass_a, sig_a, busy_a, misr_clr_a} !== {1'b1, r.pass, r.sig, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL verdict: got done=%b pass=%b sig=%h busy=%b clr=%b, want done=1 pass=%b sig=%h busy=0 clr=1",
               done_a, pass_a, sig_a, busy_a, misr_clr_a, r.pass, r.sig);
    end
  endtask

  task automatic test_golden_mismatch();
    run7(4'h5, 1'b0);
  endtask

  task automatic test_golden_match();
    run7(4'hA, 1'b1);
  endtask

  task automatic test_restart_from_done();
    vectors++;
    if (done_a !== 1'b1 || pass_a !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_precond: got done=%b pass=%b, want 1 1", done_a, pass_a);
    end
    run7(4'hA, 1'b1);
  endtask

  task automatic test_patterns9();
    logic [2:0] table9 [9];
    int zeros;
    table9 = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001, 3'b010};
    zeros = 0;
    vectors++;
    if (misr_clr_b !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_idle_b: got misr_clr=%b, want 1", misr_clr_b);
    end
    start_b = 1'b1;
    for (int i = 0; i < 9; i++) pat_q.push_back(table9[i]);
    wait_edge();  // edge 0: INIT
    start_b = 1'b0;
    if (misr_clr_b === 1'b0) zeros++;
    for (int e = 1; e <= 9; e++) begin
      logic [2:0] p;
      wait_edge();
      p = pat_q.pop_front();
      vectors++;
      if (tpg_b !== p || misr_clr_b !== 1'b0) begin
        miscompares++;
        $display("FAIL pattern9: run cycle %0d got tpg=%b clr=%b, want tpg=%b clr=0", e, tpg_b, misr_clr_b, p);
      end
      if (misr_clr_b === 1'b0) zeros++;
    end
    for (int e = 10; e <= 14; e++) begin
      wait_edge();
      if (misr_clr_b === 1'b0) zeros++;
      if (e == 11) begin
        vectors++;
        if (done_b !== 1'b1) begin
          miscompares++;
          $display("FAIL done9: got done=%b at edge 11, want 1", done_b);
        end
      end
    end
    vectors++;
    if (zeros != 10) begin
      miscompares++;
      $display("FAIL clr_low_cycles: got %0d cycles with misr_clr=0, want 10", zeros);
    end
  endtask

  task automatic test_busy_abort();
    logic [3:0] prev_sig;
    prev_sig = sig_a;
    start_a  = 1'b1;
    wait_edge();  // INIT
    start_a = 1'b0;
    wait_edge();  // RUN cycle 1
    start_a = 1'b1;  // must be ignored while busy
    wait_edge();  // RUN cycle 2
    start_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b1 || tpg_a !== 3'b010) begin
      miscompares++;
      $display("FAIL start_ignored: got busy=%b tpg=%b, want busy=1 tpg=010", busy_a, tpg_a);
    end
    wait_edge();  // RUN cycle 3
    abort_a = 1'b1;
    start_a = 1'b1;  // abort wins while busy
    wait_edge();
    abort_a = 1'b0;
    start_a = 1'b0;
    vectors++;
    if ({busy_a, done_a, pass_a, misr_clr_a, test_mode_a, sig_a} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, prev_sig}) begin
      miscompares++;
      $display("FAIL abort_run: got busy/done/pass/clr/tm/sig=%b %b %b %b %b %h, want 0 0 0 1 0 %h",
               busy_a, done_a, pass_a, misr_clr_a, test_mode_a, sig_a, prev_sig);
    end
    abort_a = 1'b1;
    start_a = 1'b1;  // start wins in IDLE
    wait_edge();
    start_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL start_priority_idle: got busy=%b, want 1", busy_a);
    end
    wait_edge();  // abort still high in INIT
    abort_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b0 || misr_clr_a !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_init: got busy=%b clr=%b, want 0 1", busy_a, misr_clr_a);
    end
  endtask

  task automatic test_async_reset();
    start_a = 1'b1;
    wait_edge();
    start_a = 1'b0;
    misr_a  = 4'hA;
    for (int e = 1; e <= 8; e++) wait_edge();  // now in COMPARE
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({busy_a, done_a, pass_a, test_mode_a, misr_clr_a, sig_a, tpg_a} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 3'b001}) begin
      miscompares++;
      $display("FAIL async_reset: got busy/done/pass/tm/clr/sig/tpg=%b %b %b %b %b %h %b, want 0 0 0 0 1 0 001",
               busy_a, done_a, pass_a, test_mode_a, misr_clr_a, sig_a, tpg_a);
    end
    #2 reset = 1'b0;
    run7(4'hA, 1'b1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; misr_a = 4'h0;
    start_b = 1'b0; abort_b = 1'b0; misr_b = 4'h0;
    test_reset();
    wait_edge();
    test_golden_mismatch();
    test_golden_match();
    test_restart_from_done();
    test_patterns9();
    test_busy_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
